// File: rtl/conv_pool_out_pkg.sv
// conv_pool_out shared constants and helpers.
// Also reused by the next-layer input buffer.
package conv_pool_out_pkg;

  localparam int XS_DEF  = 32;
  localparam int WS_DEF  = 5;
  localparam int CONV_SZ = XS_DEF - WS_DEF + 1;
  localparam int POOL_SZ = CONV_SZ / 2;
  localparam int ACT_W   = 8;
  localparam int ACT_MAX = 127;

  function automatic logic [ACT_W-1:0] act_max2(
    input logic [ACT_W-1:0] a,
    input logic [ACT_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_pool_out_if.sv
// Partial-sum in / pooled activation out bundle.
// No backpressure: both directions are valid-only.
interface conv_pool_out_if #(
  parameter int BW = 16
);
  import conv_pool_out_pkg::*;

  logic signed [BW-1:0] iPsum;
  logic                 iValid;
  logic [ACT_W-1:0]     oData;
  logic                 oValid;
  logic                 oLast;

  modport master (
    output iPsum, iValid,
    input  oData, oValid, oLast
  );

  modport slave (
    input  iPsum, iValid,
    output oData, oValid, oLast
  );

endinterface

// File: rtl/relu_requant.sv
// ReLU, arithmetic right shift and clamp to 0..ACT_MAX.
// Purely combinational.
module relu_requant
  import conv_pool_out_pkg::*;
#(
  parameter int BW    = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [BW-1:0] psum,
  output logic [ACT_W-1:0]     q
);

  logic [BW-1:0] sh;

  always_comb begin
    sh = psum[BW-1] ? '0 : ($unsigned(psum) >> SHIFT);
    q  = (sh > BW'(ACT_MAX)) ? ACT_W'(ACT_MAX)
                             : sh[ACT_W-1:0];
  end

endmodule

// File: rtl/conv_pool_out.sv
// Border discard, requant and 2x2/s2 max pool of
// the raster-order 5x5 conv partial-sum stream.
module conv_pool_out
  import conv_pool_out_pkg::*;
#(
  parameter int BW    = 16,
  parameter int XS    = XS_DEF,
  parameter int WS    = WS_DEF,
  parameter int SHIFT = 4
) (
  input logic            iCLK,
  input logic            iRST,
  conv_pool_out_if.slave bus
);

  localparam int CONV = XS - WS + 1;
  localparam int POOL = CONV / 2;
  localparam int CW   = $clog2(XS);
  localparam int PW   = $clog2(POOL);

  localparam logic [CW-1:0] LAST_POS = CW'(XS - 1);
  localparam logic [CW-1:0] BORDER   = CW'(WS - 1);

  if ((CONV % 2) != 0) begin : g_conv_odd
    $error("conv grid side must be even");
  end

  logic [CW-1:0]    c_q, c_d;
  logic [CW-1:0]    r_q, r_d;
  logic [CW-1:0]    cc;
  logic             cr_odd;
  logic [PW-1:0]    idx;
  logic             conv_ok;
  logic             at_end;
  logic [ACT_W-1:0] q;
  logic [ACT_W-1:0] hmax;
  logic [ACT_W-1:0] vmax;
  logic [ACT_W-1:0] hreg_q, hreg_d;
  logic [ACT_W-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;
  logic [ACT_W-1:0] lbuf_q [POOL];
  logic [ACT_W-1:0] lbuf_d [POOL];

  relu_requant #(
    .BW    (BW),
    .SHIFT (SHIFT)
  ) u_rq (
    .psum (bus.iPsum),
    .q    (q)
  );

  always_comb begin
    cc      = c_q - BORDER;
    cr_odd  = r_q[0] ^ BORDER[0];
    idx     = cc[PW:1];
    at_end  = (c_q == LAST_POS) && (r_q == LAST_POS);
    conv_ok = bus.iValid && (r_q >= BORDER)
              && (c_q >= BORDER);
    hmax    = act_max2(hreg_q, q);
    vmax    = act_max2(lbuf_q[idx], hmax);

    c_d      = c_q;
    r_d      = r_q;
    hreg_d   = hreg_q;
    lbuf_d   = lbuf_q;
    ovalid_d = 1'b0;
    olast_d  = 1'b0;
    odata_d  = odata_q;

    if (bus.iValid) begin
      if (c_q == LAST_POS) begin
        c_d = '0;
        r_d = (r_q == LAST_POS) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end

    // even column: stash; odd column: pool the pair
    if (conv_ok && !cc[0]) begin
      hreg_d = q;
    end
    if (conv_ok && cc[0] && !cr_odd) begin
      lbuf_d[idx] = hmax;
    end
    if (conv_ok && cc[0] && cr_odd) begin
      ovalid_d = 1'b1;
      olast_d  = at_end;
      odata_d  = vmax;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      c_q      <= '0;
      r_q      <= '0;
      hreg_q   <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      for (int i = 0; i < POOL; i++) begin
        lbuf_q[i] <= '0;
      end
    end else begin
      c_q      <= c_d;
      r_q      <= r_d;
      hreg_q   <= hreg_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      lbuf_q   <= lbuf_d;
    end
  end

  assign bus.oData  = odata_q;
  assign bus.oValid = ovalid_q;
  assign bus.oLast  = olast_q;

endmodule

// File: tb/tb_conv_pool_out.sv
// Bench for conv_pool_out: pattern table plus
// random frames against a window-max reference.
module tb_conv_pool_out;
  import conv_pool_out_pkg::*;

  localparam int XS   = 32;
  localparam int NPIX = XS * XS;
  localparam int NOUT = 196;

  typedef struct {
    int  data;
    bit  last;
    int  idx;
  } out_t;

  typedef struct {
    string name;
    int    pat;
    int    first;
    int    rest;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_pool_out_if #(.BW(16)) bus ();

  conv_pool_out #(
    .BW    (16),
    .XS    (32),
    .WS    (5),
    .SHIFT (4)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  out_t obs_q[$];
  out_t exp_q[$];
  int   ref_q[$];
  int   fr[2][NPIX];
  int   cur_idx = -1;
  int   prev_idx = -1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[5];

  always @(posedge clk)
    prev_idx <= (bus.iValid && !rst) ? cur_idx : -1;

  always @(negedge clk) begin
    out_t o;
    if (bus.oLast) begin
      total++;
      if (!bus.oValid) begin
        bad++;
        $display("FAIL olast_alone oValid=%0b want 1 t=%0t",
                 bus.oValid, $time);
      end
    end
    if (bus.oValid) begin
      total++;
      if (prev_idx < 0) begin
        bad++;
        $display("FAIL spurious_out oValid=1 want 0 t=%0t",
                 $time);
      end
      o.data = int'(bus.oData);
      o.last = bus.oLast;
      o.idx  = prev_idx;
      obs_q.push_back(o);
    end
  end

  function automatic int qm(int v);
    int s;
    if (v < 0) return 0;
    s = v / 16;
    return (s > 127) ? 127 : s;
  endfunction

  function automatic int pat_val(int pat, int r, int c);
    case (pat)
      0: return 16;
      1: return (r < 4 || c < 4) ? 1000 : 0;
      2: begin
        if (r == 4 && c == 4) return 32;
        if (r == 4 && c == 5) return 48;
        if (r == 5 && c == 4) return -500;
        if (r == 5 && c == 5) return 80;
        return 0;
      end
      3: return 32767;
      default: return -32768;
    endcase
  endfunction

  // each pooled output is the max over its 2x2 conv window
  task automatic build_exp(int f);
    out_t e;
    int   m;
    for (int pr = 0; pr < 14; pr++) begin
      for (int pc = 0; pc < 14; pc++) begin
        m = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            int v;
            v = qm(fr[f][(4 + 2*pr + dy) * XS
                         + 4 + 2*pc + dx]);
            if (v > m) m = v;
          end
        end
        e.data = m;
        e.last = (pr == 13 && pc == 13);
        e.idx  = (5 + 2*pr) * XS + 5 + 2*pc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive(int f, int maxgap, int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        cur_idx = -1;
      end
      @(posedge clk); #1;
      bus.iValid = 1'b1;
      bus.iPsum  = 16'(fr[f][i]);
      cur_idx    = i;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.iValid = 1'b0;
      cur_idx = -1;
    end
  endtask

  task automatic check_model(string nm);
    int n;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_count got %0d want %0d",
               nm, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size()
                                      : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_q[i].data != exp_q[i].data ||
          obs_q[i].last != exp_q[i].last ||
          obs_q[i].idx  != exp_q[i].idx) begin
        bad++;
        $display("FAIL %s[%0d] got d=%0d l=%0b beat=%0d want d=%0d l=%0b beat=%0d",
                 nm, i, obs_q[i].data, obs_q[i].last,
                 obs_q[i].idx, exp_q[i].data,
                 exp_q[i].last, exp_q[i].idx);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_table(vec_t v);
    int nb;
    int want;
    nb = 0;
    total++;
    if (obs_q.size() != NOUT) begin
      bad++;
      $display("FAIL %s_tcount got %0d want %0d",
               v.name, obs_q.size(), NOUT);
    end
    foreach (obs_q[i]) begin
      want = (i == 0) ? v.first : v.rest;
      if (obs_q[i].data != want) nb++;
    end
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL %s_values got %0d wrong want 0",
               v.name, nb);
    end
  endtask

  initial begin
    vecs[0] = '{"const",   0, 1,   1};
    vecs[1] = '{"border",  1, 0,   0};
    vecs[2] = '{"maxsel",  2, 5,   0};
    vecs[3] = '{"sat_pos", 3, 127, 127};
    vecs[4] = '{"sat_neg", 4, 0,   0};

    rst        = 1'b1;
    bus.iValid = 1'b1;
    bus.iPsum  = 16'sd1000;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.oValid !== 1'b0 || bus.oData !== 8'd0 ||
          bus.oLast !== 1'b0) begin
        bad++;
        $display("FAIL reset got v=%0b d=%0d l=%0b want 0 0 0",
                 bus.oValid, bus.oData, bus.oLast);
      end
    end
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.iValid = 1'b0;

    foreach (vecs[k]) begin
      for (int i = 0; i < NPIX; i++)
        fr[0][i] = pat_val(vecs[k].pat, i / XS, i % XS);
      build_exp(0);
      drive(0, 0, NPIX);
      idle(3);
      check_table(vecs[k]);
      check_model(vecs[k].name);
    end

    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NPIX; i++)
        fr[f][i] = int'($urandom_range(0, 3200)) - 1000;

    build_exp(0);
    build_exp(1);
    drive(0, 0, NPIX);
    drive(1, 0, NPIX);
    idle(3);
    foreach (obs_q[i]) ref_q.push_back(obs_q[i].data);
    check_model("nogap");

    build_exp(0);
    build_exp(1);
    drive(0, 3, NPIX);
    drive(1, 3, NPIX);
    idle(3);
    total++;
    if (obs_q.size() != ref_q.size()) begin
      bad++;
      $display("FAIL gap_len got %0d want %0d",
               obs_q.size(), ref_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
      total++;
      if (obs_q[i].data != ref_q[i]) begin
        bad++;
        $display("FAIL gap_seq[%0d] got %0d want %0d",
                 i, obs_q[i].data, ref_q[i]);
      end
    end
    check_model("gap");

    drive(0, 0, 500);
    @(posedge clk); #1;
    rst        = 1'b1;
    bus.iValid = 1'b1;
    bus.iPsum  = 16'sd1000;
    cur_idx    = -1;
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.iValid = 1'b0;
    obs_q.delete();
    exp_q.delete();
    build_exp(1);
    drive(1, 0, NPIX);
    idle(3);
    check_model("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
